// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the single-clock FIFO: width math, flag bundle and
// parameter legality.
package sync_fifo_pkg;

  localparam int DEFAULT_WIDTH    = 16;
  localparam int DEFAULT_DEPTH    = 8;
  localparam int DEFAULT_AE_LEVEL = 1;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int depth, input int ae, input int af);
    return is_pow2(depth) && (depth >= 2) && (ae >= 0) && (ae < af) && (af <= depth);
  endfunction

  // Flag values for a given occupancy; the controller registers these
  // alongside the count so that no flag depends on the current request.
  function automatic fifo_flags_t flags_for(input int count, input int depth,
                                            input int af, input int ae);
    fifo_flags_t f;
    f.full         = (count == depth);
    f.empty        = (count == 0);
    f.almost_full  = (count >= af);
    f.almost_empty = (count <= ae);
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Push/pop/status bundle between a FIFO (slave) and its user (master).
interface sync_fifo_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             i_push;
  logic [WIDTH-1:0] i_wdata;
  logic             i_pop;
  logic [WIDTH-1:0] o_rdata;
  logic             o_full;
  logic             o_empty;
  logic             o_almost_full;
  logic             o_almost_empty;
  logic [CW-1:0]    o_count;
  logic             o_overflow;
  logic             o_underflow;

  modport master (
    output i_push, i_wdata, i_pop,
    input  o_rdata, o_full, o_empty, o_almost_full, o_almost_empty,
           o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_push, i_wdata, i_pop,
    output o_rdata, o_full, o_empty, o_almost_full, o_almost_empty,
           o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl_ram.sv
// FIFO storage: synchronous write, asynchronous read, contents not reset.
module fifo_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int ADDR  = 3
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [ADDR-1:0]  i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [ADDR-1:0]  i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy count, registered
// flags, overflow/underflow pulses and the read-data path (standard or FWFT).
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = DEFAULT_AE_LEVEL
) (
  input  logic              i_clk,
  input  logic              i_rst,
  sync_fifo_ctrl_if.slave   bus
);

  localparam int ADDR = clog2(DEPTH);
  localparam int CW   = ADDR + 1;
  localparam fifo_flags_t RST_FLAGS = flags_for(0, DEPTH, AF_LEVEL, AE_LEVEL);

  if (!params_ok(DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_params
    $error("sync_fifo_ctrl: DEPTH must be a power of two >= 2 and 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [ADDR-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  fifo_flags_t      flags_q, flags_d;
  logic             overflow_q, underflow_q;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] ram_rdata;

  // A pop needs a stored word; a push into a full FIFO is allowed only
  // when a pop frees a slot at the same edge.
  assign pop_ok  = bus.i_pop & ~flags_q.empty;
  assign push_ok = bus.i_push & (~flags_q.full | pop_ok);

  // Next pointers, count and the flags that go with the new count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ADDR'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
    flags_d = flags_for(int'(count_d), DEPTH, AF_LEVEL, AE_LEVEL);
  end

  // Controller state; error pulses last exactly one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      flags_q     <= RST_FLAGS;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      flags_q     <= flags_d;
      overflow_q  <= bus.i_push & flags_q.full & ~pop_ok;
      underflow_q <= bus.i_pop & flags_q.empty;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR  (ADDR)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (push_ok),
    .i_waddr (wr_ptr_q),
    .i_wdata (bus.i_wdata),
    .i_raddr (rd_ptr_q),
    .o_rdata (ram_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word is shown directly; forced to zero while empty so the
    // output is clean out of reset.
    assign bus.o_rdata = flags_q.empty ? '0 : ram_rdata;
  end else begin : g_std
    logic [WIDTH-1:0] rdata_q;

    // Read register loads the head word on an accepted pop, holds otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)       rdata_q <= '0;
      else if (pop_ok) rdata_q <= ram_rdata;
    end

    assign bus.o_rdata = rdata_q;
  end

  assign bus.o_full         = flags_q.full;
  assign bus.o_empty        = flags_q.empty;
  assign bus.o_almost_full  = flags_q.almost_full;
  assign bus.o_almost_empty = flags_q.almost_empty;
  assign bus.o_count        = count_q;
  assign bus.o_overflow     = overflow_q;
  assign bus.o_underflow    = underflow_q;

endmodule
